// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch, hazard and writeback inputs plus the registered D/E outputs.
// Modports:
//   slave  - decode stage view (fetch/hazard/writeback in, execute out)
//   master - surrounding pipeline / bench view (the reverse)
interface decode_stage_if;
    // fetch
    logic [31:0] instruction_fetch;
    logic [31:0] pc_fetch;
    logic [31:0] next_pc_fetch;
    // hazard control
    logic        stall_decode;
    logic        flush_decode;
    // writeback
    logic        reg_write_writeback;
    logic [4:0]  rd_writeback;
    logic [31:0] result_writeback;
    // execute data
    logic [31:0] rs1_data_execute;
    logic [31:0] rs2_data_execute;
    logic [31:0] imm_execute;
    logic [31:0] pc_execute;
    logic [31:0] next_pc_execute;
    logic [4:0]  rs1_execute;
    logic [4:0]  rs2_execute;
    logic [4:0]  rd_execute;
    logic [2:0]  funct3_execute;
    // execute control
    logic        valid_execute;
    logic [3:0]  alu_control_execute;
    logic        alu_src_a_execute;
    logic        alu_src_b_execute;
    logic        reg_write_execute;
    logic        mem_write_execute;
    logic [1:0]  result_src_execute;
    logic        branch_execute;
    logic        jump_execute;
    logic        illegal_execute;

    modport slave (
        input  instruction_fetch, pc_fetch, next_pc_fetch,
        input  stall_decode, flush_decode,
        input  reg_write_writeback, rd_writeback, result_writeback,
        output rs1_data_execute, rs2_data_execute, imm_execute, pc_execute, next_pc_execute,
        output rs1_execute, rs2_execute, rd_execute, funct3_execute,
        output valid_execute, alu_control_execute, alu_src_a_execute, alu_src_b_execute,
        output reg_write_execute, mem_write_execute, result_src_execute,
        output branch_execute, jump_execute, illegal_execute
    );

    modport master (
        output instruction_fetch, pc_fetch, next_pc_fetch,
        output stall_decode, flush_decode,
        output reg_write_writeback, rd_writeback, result_writeback,
        input  rs1_data_execute, rs2_data_execute, imm_execute, pc_execute, next_pc_execute,
        input  rs1_execute, rs2_execute, rd_execute, funct3_execute,
        input  valid_execute, alu_control_execute, alu_src_a_execute, alu_src_b_execute,
        input  reg_write_execute, mem_write_execute, result_src_execute,
        input  branch_execute, jump_execute, illegal_execute
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: 32x32 register file, instruction decode, immediate generation
// and the D/E pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (clears D/E outputs and register file)
//   bus  - decode_stage_if.slave (fetch, stall/flush, writeback in; D/E outputs out)
// Configuration:
//   WB_BYPASS_EN - when defined, a same-cycle writeback to a source register is
//                  forwarded to the read (write-first); otherwise the old value is read.
module decode_stage (
    input  logic            clk,
    input  logic            rst,
    decode_stage_if.slave   bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned ALU_W  = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    logic [XLEN-1:0] regs [NREGS];

    logic [31:0]      inst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [4:0]       rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

    logic             nxt_valid, nxt_illegal, nxt_src_a, nxt_src_b;
    logic             nxt_reg_write, nxt_mem_write, nxt_branch, nxt_jump;
    logic [ALU_W-1:0] nxt_alu;
    logic [1:0]       nxt_result_src;
    logic [XLEN-1:0]  nxt_imm;

    // ALU op for the funct3 group shared by R-type and I-type arithmetic.
    function automatic logic [ALU_W-1:0] arith_alu(input logic [2:0] f3, input logic alt,
                                                    input logic allow_sub);
        logic [ALU_W-1:0] op;
        unique case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Field extraction and sign-extended immediates.
    always_comb begin
        inst    = bus.instruction_fetch;
        opcode  = inst[6:0];
        funct3  = inst[14:12];
        rs1_idx = inst[19:15];
        rs2_idx = inst[24:20];
        rd_idx  = inst[11:7];
        imm_i   = {{20{inst[31]}}, inst[31:20]};
        imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u   = {inst[31:12], 12'h000};
        imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    end

    // Register file: x0 is never written and always reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.reg_write_writeback && (bus.rd_writeback != 5'd0)) begin
            regs[bus.rd_writeback] <= bus.result_writeback;
        end
    end

    // Source operand reads, optionally forwarding a same-cycle writeback.
    always_comb begin
        rs1_val = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
        rs2_val = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];
`ifdef WB_BYPASS_EN
        if (bus.reg_write_writeback && (bus.rd_writeback != 5'd0)) begin
            if (bus.rd_writeback == rs1_idx) rs1_val = bus.result_writeback;
            if (bus.rd_writeback == rs2_idx) rs2_val = bus.result_writeback;
        end
`endif
    end

    // Control decode; an all-zero word is a bubble and leaves every control at 0.
    always_comb begin
        nxt_valid      = 1'b0;
        nxt_illegal    = 1'b0;
        nxt_src_a      = 1'b0;
        nxt_src_b      = 1'b0;
        nxt_reg_write  = 1'b0;
        nxt_mem_write  = 1'b0;
        nxt_branch     = 1'b0;
        nxt_jump       = 1'b0;
        nxt_alu        = ALU_ADD;
        nxt_result_src = RES_ALU;
        nxt_imm        = '0;
        if (inst != 32'd0) begin
            nxt_valid = 1'b1;
            unique case (opcode)
                OP_R: begin
                    nxt_reg_write = 1'b1;
                    nxt_alu       = arith_alu(funct3, inst[30], 1'b1);
                end
                OP_I: begin
                    nxt_reg_write = 1'b1;
                    nxt_src_b     = 1'b1;
                    nxt_imm       = imm_i;
                    nxt_alu       = arith_alu(funct3, inst[30], 1'b0);
                end
                OP_LOAD: begin
                    nxt_reg_write  = 1'b1;
                    nxt_src_b      = 1'b1;
                    nxt_imm        = imm_i;
                    nxt_result_src = RES_MEM;
                end
                OP_STORE: begin
                    nxt_mem_write = 1'b1;
                    nxt_src_b     = 1'b1;
                    nxt_imm       = imm_s;
                end
                OP_BRANCH: begin
                    nxt_branch = 1'b1;
                    nxt_imm    = imm_b;
                    nxt_alu    = ALU_SUB;
                end
                OP_JAL: begin
                    // ALU computes the target as PC + imm.
                    nxt_jump       = 1'b1;
                    nxt_reg_write  = 1'b1;
                    nxt_result_src = RES_PC4;
                    nxt_src_a      = 1'b1;
                    nxt_src_b      = 1'b1;
                    nxt_imm        = imm_j;
                end
                OP_JALR: begin
                    nxt_jump       = 1'b1;
                    nxt_reg_write  = 1'b1;
                    nxt_result_src = RES_PC4;
                    nxt_src_b      = 1'b1;
                    nxt_imm        = imm_i;
                end
                OP_LUI: begin
                    nxt_reg_write = 1'b1;
                    nxt_src_b     = 1'b1;
                    nxt_imm       = imm_u;
                    nxt_alu       = ALU_PASSB;
                end
                OP_AUIPC: begin
                    nxt_reg_write = 1'b1;
                    nxt_src_a     = 1'b1;
                    nxt_src_b     = 1'b1;
                    nxt_imm       = imm_u;
                end
                default: begin
                    nxt_illegal = 1'b1;
                end
            endcase
        end
    end

    // D/E pipeline register: flush beats stall, stall holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rs1_data_execute    <= '0;
            bus.rs2_data_execute    <= '0;
            bus.imm_execute         <= '0;
            bus.pc_execute          <= '0;
            bus.next_pc_execute     <= '0;
            bus.rs1_execute         <= '0;
            bus.rs2_execute         <= '0;
            bus.rd_execute          <= '0;
            bus.funct3_execute      <= '0;
            bus.valid_execute       <= 1'b0;
            bus.alu_control_execute <= '0;
            bus.alu_src_a_execute   <= 1'b0;
            bus.alu_src_b_execute   <= 1'b0;
            bus.reg_write_execute   <= 1'b0;
            bus.mem_write_execute   <= 1'b0;
            bus.result_src_execute  <= '0;
            bus.branch_execute      <= 1'b0;
            bus.jump_execute        <= 1'b0;
            bus.illegal_execute     <= 1'b0;
        end else if (bus.flush_decode) begin
            bus.rs1_data_execute    <= '0;
            bus.rs2_data_execute    <= '0;
            bus.imm_execute         <= '0;
            bus.pc_execute          <= '0;
            bus.next_pc_execute     <= '0;
            bus.rs1_execute         <= '0;
            bus.rs2_execute         <= '0;
            bus.rd_execute          <= '0;
            bus.funct3_execute      <= '0;
            bus.valid_execute       <= 1'b0;
            bus.alu_control_execute <= '0;
            bus.alu_src_a_execute   <= 1'b0;
            bus.alu_src_b_execute   <= 1'b0;
            bus.reg_write_execute   <= 1'b0;
            bus.mem_write_execute   <= 1'b0;
            bus.result_src_execute  <= '0;
            bus.branch_execute      <= 1'b0;
            bus.jump_execute        <= 1'b0;
            bus.illegal_execute     <= 1'b0;
        end else if (!bus.stall_decode) begin
            bus.rs1_data_execute    <= rs1_val;
            bus.rs2_data_execute    <= rs2_val;
            bus.imm_execute         <= nxt_imm;
            bus.pc_execute          <= bus.pc_fetch;
            bus.next_pc_execute     <= bus.next_pc_fetch;
            bus.rs1_execute         <= rs1_idx;
            bus.rs2_execute         <= rs2_idx;
            bus.rd_execute          <= rd_idx;
            bus.funct3_execute      <= funct3;
            bus.valid_execute       <= nxt_valid;
            bus.alu_control_execute <= nxt_alu;
            bus.alu_src_a_execute   <= nxt_src_a;
            bus.alu_src_b_execute   <= nxt_src_b;
            bus.reg_write_execute   <= nxt_reg_write;
            bus.mem_write_execute   <= nxt_mem_write;
            bus.result_src_execute  <= nxt_result_src;
            bus.branch_execute      <= nxt_branch;
            bus.jump_execute        <= nxt_jump;
            bus.illegal_execute     <= nxt_illegal;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, stall/flush and
// asynchronous-reset sequences, then randomized instructions against a reference model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [3:0]  alu;
        logic        src_a;
        logic        src_b;
        logic        rw;
        logic        mw;
        logic [1:0]  rsrc;
        logic        br;
        logic        jp;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic        wen;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        evalid;
        logic        eill;
        logic [3:0]  ealu;
        logic [31:0] eimm;
        logic [31:0] ers1d;
        string       name;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] mreg [32];
    exp_t held;

    // ALU code by funct3 for the arithmetic groups, before the funct7[5] variants.
    logic [3:0] f3_alu [8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};

    function automatic exp_t actual();
        exp_t a;
        a.valid = bus.valid_execute;       a.illegal = bus.illegal_execute;
        a.alu   = bus.alu_control_execute; a.src_a = bus.alu_src_a_execute;
        a.src_b = bus.alu_src_b_execute;   a.rw = bus.reg_write_execute;
        a.mw    = bus.mem_write_execute;   a.rsrc = bus.result_src_execute;
        a.br    = bus.branch_execute;      a.jp = bus.jump_execute;
        a.rs1d  = bus.rs1_data_execute;    a.rs2d = bus.rs2_data_execute;
        a.imm   = bus.imm_execute;         a.pc = bus.pc_execute;
        a.npc   = bus.next_pc_execute;     a.rs1 = bus.rs1_execute;
        a.rs2   = bus.rs2_execute;         a.rd = bus.rd_execute;
        a.f3    = bus.funct3_execute;
        return a;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wen,
                                               input logic [4:0] wrd, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wen && wrd == idx) return wdata;
`endif
        return mreg[idx];
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] npc, input logic [31:0] v1,
                                        input logic [31:0] v2);
        exp_t e;
        logic [31:0] ii, is, ib, iu, ij;
        e = '0;
        e.pc = pc; e.npc = npc; e.rs1d = v1; e.rs2d = v2;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu = {ins[31:12], 12'h000};
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        if (ins == 32'd0) return e;
        e.valid = 1'b1;
        case (ins[6:0])
            7'h33: begin
                e.rw = 1'b1; e.alu = f3_alu[ins[14:12]];
                if (ins[30] && ins[14:12] == 3'd0) e.alu = 4'h1;
                if (ins[30] && ins[14:12] == 3'd5) e.alu = 4'h7;
            end
            7'h13: begin
                e.rw = 1'b1; e.src_b = 1'b1; e.imm = ii; e.alu = f3_alu[ins[14:12]];
                if (ins[30] && ins[14:12] == 3'd5) e.alu = 4'h7;
            end
            7'h03: begin e.rw = 1'b1; e.src_b = 1'b1; e.imm = ii; e.rsrc = 2'b01; end
            7'h23: begin e.mw = 1'b1; e.src_b = 1'b1; e.imm = is; end
            7'h63: begin e.br = 1'b1; e.imm = ib; e.alu = 4'h1; end
            7'h6F: begin e.jp = 1'b1; e.rw = 1'b1; e.rsrc = 2'b10; e.src_a = 1'b1;
                         e.src_b = 1'b1; e.imm = ij; end
            7'h67: begin e.jp = 1'b1; e.rw = 1'b1; e.rsrc = 2'b10; e.src_b = 1'b1; e.imm = ii; end
            7'h37: begin e.rw = 1'b1; e.src_b = 1'b1; e.imm = iu; e.alu = 4'hA; end
            7'h17: begin e.rw = 1'b1; e.src_a = 1'b1; e.src_b = 1'b1; e.imm = iu; end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        held = '0;
    endtask

    // One cycle: drive at negedge, clock, compare at the following negedge.
    task automatic step(input logic [31:0] ins, input logic stall, input logic flush,
                        input logic wen, input logic [4:0] wrd, input logic [31:0] wdata,
                        input string name);
        exp_t e;
        logic [31:0] pc;
        pc = $urandom() & 32'hFFFF_FFFC;
        bus.instruction_fetch   = ins;
        bus.pc_fetch            = pc;
        bus.next_pc_fetch       = pc + 32'd4;
        bus.stall_decode        = stall;
        bus.flush_decode        = flush;
        bus.reg_write_writeback = wen;
        bus.rd_writeback        = wrd;
        bus.result_writeback    = wdata;
        if (flush) e = '0;
        else if (stall) e = held;
        else e = ref_decode(ins, pc, pc + 32'd4, model_read(ins[19:15], wen, wrd, wdata),
                            model_read(ins[24:20], wen, wrd, wdata));
        @(posedge clk);
        if (wen && wrd != 5'd0) mreg[wrd] = wdata;
        held = e;
        @(negedge clk);
        check(name, actual(), e);
    endtask

    vec_t vt [13];

    initial begin
        vt[0]  = '{32'h00500093, 0, 0, 0,            1, 0, 4'h0, 32'h5,        32'h0,        "addi_x1_5"};
        vt[1]  = '{32'h00000000, 1, 2, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0,        32'h0,        "bubble_wb_x2"};
        vt[2]  = '{32'h002101B3, 0, 0, 0,            1, 0, 4'h0, 32'h0,        32'hDEADBEEF, "add_x3_x2_x2"};
        vt[3]  = '{32'h40210233, 0, 0, 0,            1, 0, 4'h1, 32'h0,        32'hDEADBEEF, "sub"};
        vt[4]  = '{32'h40010093, 0, 0, 0,            1, 0, 4'h0, 32'h400,      32'hDEADBEEF, "addi_bit30"};
        vt[5]  = '{32'h40315093, 0, 0, 0,            1, 0, 4'h7, 32'h403,      32'hDEADBEEF, "srai"};
        vt[6]  = '{32'hFE000CE3, 0, 0, 0,            1, 0, 4'h1, 32'hFFFFFFF8, 32'h0,        "beq_m8"};
        vt[7]  = '{32'h123452B7, 0, 0, 0,            1, 0, 4'hA, 32'h12345000, 32'h0,        "lui"};
        vt[8]  = '{32'h00001297, 0, 0, 0,            1, 0, 4'h0, 32'h1000,     32'h0,        "auipc"};
        vt[9]  = '{32'h0000007F, 0, 0, 0,            1, 1, 4'h0, 32'h0,        32'h0,        "illegal_7f"};
        vt[10] = '{32'h00000333, 1, 0, 32'hFFFFFFFF, 1, 0, 4'h0, 32'h0,        32'h0,        "wr_x0"};
`ifdef WB_BYPASS_EN
        vt[11] = '{32'h00028313, 1, 5, 32'hCAFEF00D, 1, 0, 4'h0, 32'h0,        32'hCAFEF00D, "same_cycle_x5"};
`else
        vt[11] = '{32'h00028313, 1, 5, 32'hCAFEF00D, 1, 0, 4'h0, 32'h0,        32'h0,        "same_cycle_x5"};
`endif
        vt[12] = '{32'h00028313, 0, 0, 0,            1, 0, 4'h0, 32'h0,        32'hCAFEF00D, "after_x5"};

        bus.instruction_fetch = '0; bus.pc_fetch = '0; bus.next_pc_fetch = '0;
        bus.stall_decode = 1'b0; bus.flush_decode = 1'b0;
        bus.reg_write_writeback = 1'b0; bus.rd_writeback = '0; bus.result_writeback = '0;
        model_reset();

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", actual(), exp_t'('0));
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            step(vt[i].ins, 1'b0, 1'b0, vt[i].wen, vt[i].wrd, vt[i].wdata, vt[i].name);
            check32({vt[i].name, "_valid"}, 32'(bus.valid_execute), 32'(vt[i].evalid));
            check32({vt[i].name, "_illegal"}, 32'(bus.illegal_execute), 32'(vt[i].eill));
            check32({vt[i].name, "_alu"}, 32'(bus.alu_control_execute), 32'(vt[i].ealu));
            check32({vt[i].name, "_imm"}, bus.imm_execute, vt[i].eimm);
            check32({vt[i].name, "_rs1d"}, bus.rs1_data_execute, vt[i].ers1d);
        end

        // Stall for two cycles (regfile write still lands), then flush with stall.
        step(32'h00500093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "pre_stall");
        step(32'h40315093, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77, "stall_1");
        step(32'h123452B7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, "stall_2");
        check32("stall_rd_held", 32'(bus.rd_execute), 32'd1);
        step(32'h002101B3, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, "flush_over_stall");
        check32("flush_valid", 32'(bus.valid_execute), 32'd0);
        step(32'h00038413, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "read_x7_after_stall");
        check32("x7_written_in_stall", bus.rs1_data_execute, 32'h77);

        // Asynchronous reset mid-cycle, then the register file must read back zero.
        step(32'h002101B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "pre_reset");
        #2 rst = 1'b0;
        #1 check("async_reset", actual(), exp_t'('0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(32'h002101B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "post_reset_add");
        check32("post_reset_x2", bus.rs1_data_execute, 32'd0);

        // Randomized instructions against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [6:0]  ops [9];
            logic [6:0]  bad [5];
            int          k;
            ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
            bad = '{7'h7F, 7'h0F, 7'h73, 7'h00, 7'h5B};
            k = int'($urandom_range(0, 10));
            ins = $urandom();
            if (k < 9) ins[6:0] = ops[k];
            else if (k == 9) ins[6:0] = bad[$urandom_range(0, 4)];
            else ins = 32'd0;
            step(ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom()), $urandom(), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
